// File: rtl/bn_layer_sequencer_if.sv
// Handshake/bus bundle for bn_layer_sequencer: controller start/done, BN weight
// memory request, feature-map read port and output-buffer write port.
interface bn_layer_sequencer_if #(
    parameter int ADDR_W = 12
);
    logic              start;
    logic              busy;
    logic              done;
    logic [3:0]        bn_filter;
    logic              bn_start;
    logic [15:0]       bn_p;
    logic [31:0]       bn_q;
    logic              bn_done;
    logic              fmap_rd_en;
    logic [ADDR_W-1:0] fmap_rd_addr;
    logic [15:0]       fmap_rd_data;
    logic              out_wr_en;
    logic [ADDR_W-1:0] out_wr_addr;
    logic [15:0]       out_wr_data;

    modport master (
        input  start, bn_p, bn_q, bn_done, fmap_rd_data,
        output busy, done, bn_filter, bn_start, fmap_rd_en, fmap_rd_addr,
               out_wr_en, out_wr_addr, out_wr_data
    );

    modport slave (
        output start, bn_p, bn_q, bn_done, fmap_rd_data,
        input  busy, done, bn_filter, bn_start, fmap_rd_en, fmap_rd_addr,
               out_wr_en, out_wr_addr, out_wr_data
    );
endinterface

// File: rtl/bn_layer_sequencer.sv
// Batch-norm layer sequencer: per filter, load (p,q) then stream SEQ_LEN samples
// through y = sat16((x*p + q + round) >>> FRAC_BITS). Define RELU_FUSE_EN to clamp negatives to 0.
module bn_layer_sequencer #(
    parameter int NUM_FILTERS = 10,
    parameter int SEQ_LEN     = 256,
    parameter int ADDR_W      = 12,
    parameter int FRAC_BITS   = 14
) (
    input logic                  clk,
    input logic                  rst,
    bn_layer_sequencer_if.master bus
);
    localparam int POS_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(SEQ_LEN - 1);
    localparam logic [3:0]        F_LAST    = 4'(NUM_FILTERS - 1);
    localparam logic [ADDR_W-1:0] SEQ_LEN_A = ADDR_W'(SEQ_LEN);
    localparam logic signed [33:0] ROUND    = 34'sd1 <<< (FRAC_BITS - 1);
    localparam logic signed [33:0] SAT_MAX  = 34'sd32767;
    localparam logic signed [33:0] SAT_MIN  = -34'sd32768;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_NEXT, S_DONE} state_t;

    state_t             state_q;
    logic [3:0]         filter_q;
    logic [POS_W-1:0]   pos_q;
    logic [1:0]         drain_q;
    logic signed [15:0] p_q;
    logic signed [31:0] q_q;
    logic               busy_q, done_q, bn_start_q, rd_en_q;
    logic [ADDR_W-1:0]  rd_addr_q;
    logic [ADDR_W-1:0]  base_addr;

    always_comb begin
        base_addr = ADDR_W'(filter_q) * SEQ_LEN_A;
    end

    // Outputs are registered and updated on the same edge as the state, so they
    // always describe the state currently held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            filter_q   <= '0;
            pos_q      <= '0;
            drain_q    <= '0;
            p_q        <= '0;
            q_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bn_start_q <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (bus.start) begin
                    state_q    <= S_LOAD;
                    filter_q   <= '0;
                    busy_q     <= 1'b1;
                    bn_start_q <= 1'b1;
                end
                S_LOAD: if (bus.bn_done) begin
                    p_q        <= signed'(bus.bn_p);
                    q_q        <= signed'(bus.bn_q);
                    bn_start_q <= 1'b0;
                    rd_en_q    <= 1'b1;
                    rd_addr_q  <= base_addr;
                    pos_q      <= '0;
                    state_q    <= S_RUN;
                end
                S_RUN: begin
                    if (pos_q == POS_LAST) begin
                        rd_en_q <= 1'b0;
                        drain_q <= '0;
                        state_q <= S_DRAIN;
                    end else begin
                        pos_q     <= pos_q + 1'b1;
                        rd_addr_q <= rd_addr_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drain_q == 2'd2) state_q <= S_NEXT;
                    else                 drain_q <= drain_q + 2'd1;
                end
                S_NEXT: begin
                    if (filter_q == F_LAST) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        filter_q   <= filter_q + 4'd1;
                        bn_start_q <= 1'b1;
                        state_q    <= S_LOAD;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    logic               v1_q, v2_q, wr_en_q;
    logic [ADDR_W-1:0]  addr1_q, addr2_q, wr_addr_q;
    logic signed [31:0] prod_d, prod_q;
    logic signed [33:0] sum_d, shift_d;
    logic [15:0]        res_d, wr_data_q;

    always_comb begin
        prod_d  = $signed({{16{bus.fmap_rd_data[15]}}, bus.fmap_rd_data})
                * $signed({{16{p_q[15]}}, p_q});
        sum_d   = $signed({{2{prod_q[31]}}, prod_q}) + $signed({{2{q_q[31]}}, q_q}) + ROUND;
        shift_d = sum_d >>> FRAC_BITS;
        if (shift_d > SAT_MAX)      res_d = 16'h7FFF;
        else if (shift_d < SAT_MIN) res_d = 16'h8000;
        else                        res_d = shift_d[15:0];
`ifdef RELU_FUSE_EN
        if (res_d[15]) res_d = '0;
`endif
    end

    // Address travels with the data so each write lands where its sample was read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            wr_en_q   <= 1'b0;
            addr1_q   <= '0;
            addr2_q   <= '0;
            wr_addr_q <= '0;
            prod_q    <= '0;
            wr_data_q <= '0;
        end else begin
            v1_q      <= rd_en_q;
            addr1_q   <= rd_addr_q;
            v2_q      <= v1_q;
            addr2_q   <= addr1_q;
            prod_q    <= prod_d;
            wr_en_q   <= v2_q;
            wr_addr_q <= addr2_q;
            wr_data_q <= res_d;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.bn_filter    = filter_q;
    assign bus.bn_start     = bn_start_q;
    assign bus.fmap_rd_en   = rd_en_q;
    assign bus.fmap_rd_addr = rd_addr_q;
    assign bus.out_wr_en    = wr_en_q;
    assign bus.out_wr_addr  = wr_addr_q;
    assign bus.out_wr_data  = wr_data_q;
endmodule

// File: doc/bn_layer_sequencer.md
Name: bn_layer_sequencer

Overview:
Sequences one batch-norm layer over a stored feature map: y = sat16((x*p + q + round) >>> FRAC_BITS) per sample.
- Walks filters 0..NUM_FILTERS-1; for each, selects the filter on the BN weight memory and latches its (p, q) pair.
- Streams SEQ_LEN samples from the feature-map buffer through a 3-stage pipeline into the output buffer.
- Sits between the conv-layer output buffer and the next layer; a start/done handshake from the network top-level controller triggers it.

Parameters:
NUM_FILTERS, 10, filters processed (≤16, matches 4-bit filter select)
SEQ_LEN, 256, samples per filter
ADDR_W, 12, buffer address width; must satisfy 2^ADDR_W ≥ NUM_FILTERS*SEQ_LEN
FRAC_BITS, 14, fractional bits of p; right-shift applied after accumulate

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
start  in  1  level/pulse; sampled only in IDLE
busy  out  1  high from the cycle after start is accepted until DONE exits
done  out  1  one-cycle pulse at end of layer
bn_filter  out  4  filter select to BN weight memory
bn_start  out  1  request to BN weight memory, high only in LOAD
bn_p  in  16  signed scale for bn_filter (combinational from memory)
bn_q  in  32  signed offset for bn_filter
bn_done  in  1  p/q valid
fmap_rd_en  out  1  feature-map read strobe
fmap_rd_addr  out  ADDR_W  filter*SEQ_LEN + pos
fmap_rd_data  in  16  signed sample, valid 1 cycle after fmap_rd_en
out_wr_en  out  1  output buffer write strobe
out_wr_addr  out  ADDR_W  same address as the originating read
out_wr_data  out  16  signed normalized result

Behaviour:
- Reset (rst=0, async): FSM→IDLE; all outputs 0; filter/pos counters, p/q latches and pipeline valids cleared. Reset mid-layer aborts with no done pulse; the next start restarts from filter 0.
- FSM states:
  - IDLE: start=1 → LOAD with filter=0. start is ignored in every other state.
  - LOAD: bn_start=1, bn_filter=filter. When bn_done=1, latch bn_p/bn_q → RUN with pos=0. Otherwise hold LOAD indefinitely.
  - RUN: fmap_rd_en=1 every cycle, address filter*SEQ_LEN+pos, pos++. After pos=SEQ_LEN-1 is issued → DRAIN.
  - DRAIN: 3 cycles with no reads while the pipeline empties → NEXT.
  - NEXT: if filter=NUM_FILTERS-1 → DONE; else filter++ → LOAD.
  - DONE: done=1 for one cycle → IDLE. busy falls with the exit from DONE.
- Pipeline, for a read issued in cycle t:
  - t+1: product = fmap_rd_data * p (32-bit signed), registered.
  - t+2: sum = product + q + 2^(FRAC_BITS-1), computed in 34-bit signed. Arithmetic shift right by FRAC_BITS. Saturate to [-32768, 32767]. Registered into out_wr_data.
  - t+3: out_wr_en=1 with out_wr_addr = the read address (the address is delayed alongside the data).
- Read-to-write latency is exactly 3 cycles. There are no gaps inside a filter: SEQ_LEN consecutive writes per filter.
- p/q are held stable for the whole RUN+DRAIN of a filter; bn_p/bn_q changes outside LOAD have no effect.
- Timing with bn_done tied high: each filter takes SEQ_LEN+5 cycles (LOAD 1, RUN SEQ_LEN, DRAIN 3, NEXT 1). done asserts NUM_FILTERS*(SEQ_LEN+5)+1 cycles after the edge that samples start.
- Saturation flag is not exported; clamping is silent.

Optional Feature:
RELU_FUSE_EN
- Defined: stage t+2 clamps negative saturated results to 0, fusing the following ReLU. Latency and timing are unchanged.
- Undefined: signed results pass through unchanged.

Test Plan:
- Identity: all p=16384, q=0, x=100 at every address → every write = 100; 2560 writes; addresses 0..2559 in order; done after 10*261+1 cycles.
- BN value: filter 3 p=28571, q=-28612, x=1000 → out_wr_data=1742, out_wr_en exactly 3 cycles after the matching fmap_rd_en.
- Saturation: p=28571, q=0; x=32767 → 32767; x=-32768 → -32768. With RELU_FUSE_EN: x=-100, p=16384 → 0 (without the macro → -100).
- LOAD stall: hold bn_done=0 for 5 cycles at filter 2 → no fmap_rd_en during the stall; bn_filter=2 held; processing resumes and all writes are correct; done delayed by 5 cycles.
- Start while busy: pulse start mid-RUN → ignored; single done pulse; busy continuous.
- Reset mid-layer: assert rst=0 during filter 4 RUN → all outputs 0 immediately; no done; a new start processes filter 0 from address 0.
